pipeline_id_redirect: RTL and testbench
=======================================

Name: pipeline_id_redirect

Overview:
- Decode-side consumer of the fetch stream.
- Registers each fetched instruction/PC into the ID stage and statically predicts JAL and backward conditional branches as taken.
- On a predicted-taken instruction, drives redirection_d_o, taken_d_o and drain_cnt_d_o back to the fetch stage, then squashes the wrong-path shadow instructions already in flight from fetch.
- Sits between the fetch stage and the ID/EX register; flush_i comes from EX on a resolved mispredict.

Parameters:
- DRAIN_DEPTH, 2: number of sequential shadow instructions squashed after a predicted-taken redirect; legal range 0..3.
- PREDICT_BACKWARD, 1: 1 = B-type with negative offset is predicted taken; 0 = only JAL is predicted taken.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  stage advance; 0 = stall, all state and outputs hold.
- flush_i  in  1  EX redirect; kills the ID contents and the drain.
- valid_f_i  in  1  instruction_f_i/pc_f_i valid this cycle.
- instruction_f_i  in  32  fetched instruction.
- pc_f_i  in  32  PC of instruction_f_i.
- instruction_d_o  out  32  registered ID instruction.
- pc_d_o  out  32  registered ID PC.
- valid_d_o  out  1  ID instruction valid (not squashed).
- redirection_d_o  out  32  predicted target to fetch.
- taken_d_o  out  1  redirect request to fetch, one enabled cycle.
- drain_cnt_d_o  out  2  shadow instructions still to be squashed.

Behaviour:
- Reset: all outputs 0, FSM = RUN, drain counter = 0. Reset mid-drain aborts the drain.
- Update priority on a rising edge: reset > flush_i > enable = 0 > normal update.
- flush_i with reset low: valid_d_o = 0, taken_d_o = 0, drain_cnt_d_o = 0, FSM = RUN. This applies regardless of enable and wins over a same-cycle prediction.
- enable = 0: every register holds. taken_d_o held high stays high until the next enabled edge.
- Datapath latency: instruction_f_i and pc_f_i are captured on every enabled edge; outputs appear one cycle later.
- Predict condition on the incoming instruction, valid_f_i = 1 and FSM = RUN:
  - opcode 7'b1101111 (JAL), or
  - opcode 7'b1100011 and instr[31] = 1 and PREDICT_BACKWARD = 1.
  - JALR is never predicted.
- Immediates, sign-extended to 32 bits:
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - Target = pc_f_i + imm, modulo 2^32; wrap-around is permitted.
- Valid outputs:
  - RUN, enabled edge: valid_d_o <= valid_f_i.
  - DRAIN, enabled edge: valid_d_o <= 0.
- Redirect outputs, predicted edge:
  - redirection_d_o <= target.
  - taken_d_o <= 1, aligned with the branch appearing in ID.
  - drain counter <= DRAIN_DEPTH; FSM -> DRAIN, or stays RUN if DRAIN_DEPTH = 0.
  - On any other enabled edge taken_d_o <= 0; redirection_d_o holds its last value.
- FSM RUN: normal pass-through plus prediction.
- FSM DRAIN:
  - Each enabled edge with valid_f_i = 1 decrements the counter and squashes that instruction.
  - valid_f_i = 0 does not decrement.
  - The transition to RUN happens on the edge that takes the counter 1 -> 0.
  - Predictions are ignored while in DRAIN.
- drain_cnt_d_o = counter value.
- Back-to-back predicted instructions: the second one falls in the shadow and is squashed. It is not predicted.

Test Plan:
- Reset: hold reset 2 cycles with arbitrary inputs -> all outputs 0; then input NOP 0x00000013 at pc 0x0 -> next cycle valid_d_o = 1, instruction_d_o = 0x00000013, taken_d_o = 0.
- JAL: 0x0100006F at pc 0x8 -> next cycle taken_d_o = 1, redirection_d_o = 0x18, drain_cnt_d_o = 2. The next two valid inputs (pc 0xC, 0x10) give valid_d_o = 0 and drain 1 then 0. Input pc 0x18 -> valid_d_o = 1.
- Branch direction: 0xFE000CE3 (beq -8) at pc 0x20 -> taken_d_o = 1, redirection_d_o = 0x18. 0x00000463 (beq +8) -> taken_d_o = 0, valid_d_o = 1.
- Stall: drop enable for 3 cycles right after the JAL prediction -> taken_d_o stays 1 and drain_cnt_d_o stays 2. Re-enable -> taken_d_o falls and the drain proceeds.
- Flush: assert flush_i together with the JAL input, and separately mid-drain -> taken_d_o = 0, valid_d_o = 0, drain_cnt_d_o = 0. The next valid input passes through.
- Bubbles and wrap: in DRAIN, valid_f_i = 0 for 2 cycles -> count unchanged. JAL imm +16 at pc 0xFFFFFFF8 -> redirection_d_o = 0x00000008.

Source files
------------

// File: rtl/pipeline_id_redirect.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_id_redirect
// Purpose  : ID-stage register with static JAL/backward-branch prediction and
//            squashing of the sequential shadow fetched after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_id_redirect #(
    parameter int DRAIN_DEPTH      = 2,
    parameter int PREDICT_BACKWARD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush_i,
    input  logic        valid_f_i,
    input  logic [31:0] instruction_f_i,
    input  logic [31:0] pc_f_i,
    output logic [31:0] instruction_d_o,
    output logic [31:0] pc_d_o,
    output logic        valid_d_o,
    output logic [31:0] redirection_d_o,
    output logic        taken_d_o,
    output logic [1:0]  drain_cnt_d_o
);

    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [1:0] c_DRAIN_CNT = 2'(DRAIN_DEPTH);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] redir_q, redir_d;
    logic        taken_q, taken_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        w_is_jal;
    logic        w_is_bwd_branch;
    logic        w_predict;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;
    logic [31:0] w_target;

    assign w_is_jal        = (instruction_f_i[6:0] == c_OP_JAL);
    assign w_is_bwd_branch = (instruction_f_i[6:0] == c_OP_BRANCH) && instruction_f_i[31]
                             && (PREDICT_BACKWARD != 0);
    assign w_predict       = valid_f_i && (state_q == S_RUN) && (w_is_jal || w_is_bwd_branch);

    assign w_imm_j  = {{12{instruction_f_i[31]}}, instruction_f_i[19:12], instruction_f_i[20],
                       instruction_f_i[30:21], 1'b0};
    assign w_imm_b  = {{20{instruction_f_i[31]}}, instruction_f_i[7], instruction_f_i[30:25],
                       instruction_f_i[11:8], 1'b0};
    assign w_target = pc_f_i + (w_is_jal ? w_imm_j : w_imm_b);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        redir_d = redir_q;
        taken_d = taken_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            // Flush kills ID and the drain even while stalled; the datapath
            // still advances only on an enabled edge.
            if (enable) begin
                instr_d = instruction_f_i;
                pc_d    = pc_f_i;
            end
            valid_d = 1'b0;
            taken_d = 1'b0;
            cnt_d   = 2'd0;
            state_d = S_RUN;
        end else if (enable) begin
            instr_d = instruction_f_i;
            pc_d    = pc_f_i;
            taken_d = 1'b0;
            if (state_q == S_RUN) begin
                valid_d = valid_f_i;
                if (w_predict) begin
                    redir_d = w_target;
                    taken_d = 1'b1;
                    cnt_d   = c_DRAIN_CNT;
                    state_d = (DRAIN_DEPTH != 0) ? S_DRAIN : S_RUN;
                end
            end else begin
                valid_d = 1'b0;
                if (valid_f_i) begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
            redir_q <= 32'd0;
            taken_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            redir_q <= redir_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instruction_d_o = instr_q;
    assign pc_d_o          = pc_q;
    assign valid_d_o       = valid_q;
    assign redirection_d_o = redir_q;
    assign taken_d_o       = taken_q;
    assign drain_cnt_d_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_id_redirect.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_id_redirect
// Purpose  : Directed self-checking bench for pipeline_id_redirect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_id_redirect;

    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_JAL16  = 32'h0100_006F;
    localparam logic [31:0] c_BEQ_M8 = 32'hFE00_0CE3;
    localparam logic [31:0] c_BEQ_P8 = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush_i;
    logic        valid_f_i;
    logic [31:0] instruction_f_i;
    logic [31:0] pc_f_i;
    logic [31:0] instruction_d_o;
    logic [31:0] pc_d_o;
    logic        valid_d_o;
    logic [31:0] redirection_d_o;
    logic        taken_d_o;
    logic [1:0]  drain_cnt_d_o;

    int r_tests = 0;
    int r_fails = 0;

    always #5 clk = ~clk;

    pipeline_id_redirect #(
        .DRAIN_DEPTH      (2),
        .PREDICT_BACKWARD (1)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .flush_i         (flush_i),
        .valid_f_i       (valid_f_i),
        .instruction_f_i (instruction_f_i),
        .pc_f_i          (pc_f_i),
        .instruction_d_o (instruction_d_o),
        .pc_d_o          (pc_d_o),
        .valid_d_o       (valid_d_o),
        .redirection_d_o (redirection_d_o),
        .taken_d_o       (taken_d_o),
        .drain_cnt_d_o   (drain_cnt_d_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs, then sample just after the following edge.
    task automatic step(input logic en, input logic fl, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc);
        enable          = en;
        flush_i         = fl;
        valid_f_i       = v;
        instruction_f_i = ins;
        pc_f_i          = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic v, input logic t, input logic [1:0] c);
        check({tag, ".valid"}, {31'd0, valid_d_o}, {31'd0, v});
        check({tag, ".taken"}, {31'd0, taken_d_o}, {31'd0, t});
        check({tag, ".drain"}, {30'd0, drain_cnt_d_o}, {30'd0, c});
    endtask

    initial begin
        // Reset with a predictable instruction on the input
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1, c_JAL16, 32'h8);
        step(1'b1, 1'b0, 1'b1, c_JAL16, 32'h8);
        check_ctl("rst", 1'b0, 1'b0, 2'd0);
        check("rst.instr", instruction_d_o, 32'h0);
        check("rst.pc", pc_d_o, 32'h0);
        check("rst.redir", redirection_d_o, 32'h0);
        reset = 1'b0;

        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h0);
        check_ctl("nop", 1'b1, 1'b0, 2'd0);
        check("nop.instr", instruction_d_o, c_NOP);

        // JAL +16 at 0x8 and its two-instruction shadow
        step(1'b1, 1'b0, 1'b1, c_JAL16, 32'h8);
        check_ctl("jal", 1'b1, 1'b1, 2'd2);
        check("jal.redir", redirection_d_o, 32'h18);
        check("jal.pc", pc_d_o, 32'h8);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'hC);
        check_ctl("sh0", 1'b0, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h10);
        check_ctl("sh1", 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h18);
        check_ctl("tgt", 1'b1, 1'b0, 2'd0);
        check("tgt.pc", pc_d_o, 32'h18);
        check("tgt.redir_hold", redirection_d_o, 32'h18);

        // Backward beq, with bubbles inside the drain
        step(1'b1, 1'b0, 1'b1, c_BEQ_M8, 32'h20);
        check_ctl("bbwd", 1'b1, 1'b1, 2'd2);
        check("bbwd.redir", redirection_d_o, 32'h18);
        step(1'b1, 1'b0, 1'b0, c_NOP, 32'h24);
        check_ctl("bub0", 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 1'b0, c_NOP, 32'h24);
        check_ctl("bub1", 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h24);
        check_ctl("bsh0", 1'b0, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h28);
        check_ctl("bsh1", 1'b0, 1'b0, 2'd0);

        // Forward beq is not predicted
        step(1'b1, 1'b0, 1'b1, c_BEQ_P8, 32'h30);
        check_ctl("bfwd", 1'b1, 1'b0, 2'd0);
        check("bfwd.redir_hold", redirection_d_o, 32'h18);

        // Stall right after a prediction
        step(1'b1, 1'b0, 1'b1, c_JAL16, 32'h40);
        check_ctl("sjal", 1'b1, 1'b1, 2'd2);
        check("sjal.redir", redirection_d_o, 32'h50);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, c_NOP, 32'h44);
            check_ctl("stall", 1'b1, 1'b1, 2'd2);
        end
        check("stall.pc", pc_d_o, 32'h40);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h44);
        check_ctl("resume", 1'b0, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h48);
        check_ctl("resume2", 1'b0, 1'b0, 2'd0);

        // Flush together with a JAL wins over the prediction
        step(1'b1, 1'b1, 1'b1, c_JAL16, 32'h60);
        check_ctl("fjal", 1'b0, 1'b0, 2'd0);
        check("fjal.redir_hold", redirection_d_o, 32'h50);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h64);
        check_ctl("fpass", 1'b1, 1'b0, 2'd0);
        check("fpass.pc", pc_d_o, 32'h64);

        // Flush mid-drain
        step(1'b1, 1'b0, 1'b1, c_JAL16, 32'h80);
        check_ctl("mjal", 1'b1, 1'b1, 2'd2);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h84);
        check_ctl("msh0", 1'b0, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b1, c_NOP, 32'h88);
        check_ctl("mflush", 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h8C);
        check_ctl("mpass", 1'b1, 1'b0, 2'd0);
        check("mpass.pc", pc_d_o, 32'h8C);

        // Target wrap-around, then a back-to-back JAL falls in the shadow
        step(1'b1, 1'b0, 1'b1, c_JAL16, 32'hFFFF_FFF8);
        check_ctl("wrap", 1'b1, 1'b1, 2'd2);
        check("wrap.redir", redirection_d_o, 32'h0000_0008);
        step(1'b1, 1'b0, 1'b1, c_JAL16, 32'hFFFF_FFFC);
        check_ctl("b2b", 1'b0, 1'b0, 2'd1);
        check("b2b.redir_hold", redirection_d_o, 32'h0000_0008);

        // Reset mid-drain aborts the drain
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h0);
        check_ctl("rdrain", 1'b0, 1'b0, 2'd0);
        check("rdrain.redir", redirection_d_o, 32'h0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b1, c_NOP, 32'h4);
        check_ctl("rpass", 1'b1, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
